// File: rtl/pipe_reg.sv
// pipe_reg: DEPTH-stage valid/ready register pipeline with bubble collapsing.
// Each stage holds a valid bit and a data word. The ready chain lets an
// occupied stage advance whenever the stage ahead is empty or advancing, so a
// stalled output still lets upstream stages fill.
// Optional build macro PIPE_SYNC_CLR_EN adds the clr port (synchronous flush).
module pipe_reg #(
    parameter int unsigned           WIDTH   = 8,
    parameter int unsigned           DEPTH   = 4,
    parameter logic [WIDTH-1:0]      RST_VAL = '0
) (
    input  logic                             clk,
    input  logic                             rst,
`ifdef PIPE_SYNC_CLR_EN
    input  logic                             clr,
`endif
    input  logic                             in_valid,
    output logic                             in_ready,
    input  logic [WIDTH-1:0]                 in_data,
    output logic                             out_valid,
    input  logic                             out_ready,
    output logic [WIDTH-1:0]                 out_data,
    output logic [$clog2(DEPTH+1)-1:0]       count
);

    localparam int unsigned CW = $clog2(DEPTH + 1);

    logic [DEPTH-1:0] v;
    logic [WIDTH-1:0] d    [DEPTH];
    logic [DEPTH:0]   r;
    logic [DEPTH-1:0] up_v;
    logic [WIDTH-1:0] up_d [DEPTH];
    logic             flush;

`ifdef PIPE_SYNC_CLR_EN
    assign flush = clr;
`else
    assign flush = 1'b0;
`endif

    // Ready chain: a stage can take new data if it is empty or its content moves on.
    always_comb begin
        r        = '0;
        r[DEPTH] = out_ready;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            r[DEPTH-1-i] = ~v[DEPTH-1-i] | r[DEPTH-i];
        end
    end

    // Upstream view of each stage: stage 0 sees the input port, others the stage behind.
    always_comb begin
        up_v    = '0;
        up_v[0] = in_valid;
        up_d[0] = in_data;
        for (int unsigned k = 1; k < DEPTH; k++) begin
            up_v[k] = v[k-1];
            up_d[k] = d[k-1];
        end
    end

    // Valid bits: advance along the chain where ready; flush empties every stage.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            v <= '0;
        end else if (flush) begin
            v <= '0;
        end else begin
            for (int unsigned k = 0; k < DEPTH; k++) begin
                if (r[k]) begin
                    v[k] <= up_v[k];
                end
            end
        end
    end

    // Data registers: load only when a valid word actually moves in; otherwise hold.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned k = 0; k < DEPTH; k++) begin
                d[k] <= RST_VAL;
            end
        end else begin
            for (int unsigned k = 0; k < DEPTH; k++) begin
                if (r[k] && up_v[k] && !flush) begin
                    d[k] <= up_d[k];
                end
            end
        end
    end

    // Occupancy: population count of the valid bits.
    always_comb begin
        count = '0;
        for (int unsigned k = 0; k < DEPTH; k++) begin
            count = count + CW'(v[k]);
        end
    end

    assign in_ready  = r[0] & ~flush;
    assign out_valid = v[DEPTH-1];
    assign out_data  = d[DEPTH-1];

endmodule

// File: tb/tb_pipe_reg.sv
// tb_pipe_reg: directed table, hand-written corner sequences and a randomized
// run against a slot-level reference model of pipe_reg (WIDTH=8, DEPTH=4).
module tb_pipe_reg;

    localparam int          W  = 8;
    localparam int          D  = 4;
    localparam int          CW = $clog2(D + 1);
    localparam logic [7:0]  RV = 8'hA5;

    logic          clk = 1'b0;
    logic          rst;
    logic          in_valid;
    logic          in_ready;
    logic [W-1:0]  in_data;
    logic          out_valid;
    logic          out_ready;
    logic [W-1:0]  out_data;
    logic [CW-1:0] count;
`ifdef PIPE_SYNC_CLR_EN
    logic          clr;
`endif

    pipe_reg #(.WIDTH(W), .DEPTH(D), .RST_VAL(RV)) dut (
        .clk       (clk),
        .rst       (rst),
`ifdef PIPE_SYNC_CLR_EN
        .clr       (clr),
`endif
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .count     (count)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk_outs(input string tag, input logic ir, input logic ov,
                            input logic [7:0] od, input logic chk_od, input int cnt);
        chk({tag, ".in_ready"},  32'(in_ready),  32'(ir));
        chk({tag, ".out_valid"}, 32'(out_valid), 32'(ov));
        chk({tag, ".count"},     32'(count),     32'(cnt));
        if (chk_od) chk({tag, ".out_data"}, 32'(out_data), 32'(od));
    endtask

    // Apply inputs at the falling edge, settle, leaving the next rising edge to act on them.
    task automatic drive(input logic iv, input logic [7:0] din, input logic ordy);
        @(negedge clk);
        in_valid  = iv;
        in_data   = din;
        out_ready = ordy;
        #1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b0;
`ifdef PIPE_SYNC_CLR_EN
        clr       = 1'b0;
`endif
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    typedef struct {
        logic       iv;
        logic [7:0] din;
        logic       ordy;
        logic       e_ir;
        logic       e_ov;
        logic [7:0] e_od;
        logic       chk_od;
        int         e_cnt;
    } vec_t;

    vec_t tbl[13];

    // Reference model: occupied positions of the pipeline, most-downstream first.
    logic       mv [D];
    logic [7:0] md [D];

    function automatic int m_count();
        int c = 0;
        for (int k = 0; k < D; k++) if (mv[k]) c++;
        return c;
    endfunction

    task automatic m_clear();
        for (int k = 0; k < D; k++) begin
            mv[k] = 1'b0;
            md[k] = '0;
        end
    endtask

    task automatic m_step(input logic iv, input logic [7:0] din, input logic ordy);
        logic acc;
        acc = iv && ((m_count() < D) || ordy);
        if (mv[D-1] && ordy) mv[D-1] = 1'b0;
        for (int k = D - 1; k >= 1; k--) begin
            if (!mv[k] && mv[k-1]) begin
                mv[k]   = 1'b1;
                md[k]   = md[k-1];
                mv[k-1] = 1'b0;
            end
        end
        if (acc) begin
            mv[0] = 1'b1;
            md[0] = din;
        end
    endtask

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b0;
`ifdef PIPE_SYNC_CLR_EN
        clr       = 1'b0;
`endif

        // Stalled fill with 10..15, then drain: in_ready drops at 4, order kept.
        tbl[0]  = '{1'b1, 8'h10, 1'b0, 1'b1, 1'b0, RV,    1'b1, 0};
        tbl[1]  = '{1'b1, 8'h11, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 1};
        tbl[2]  = '{1'b1, 8'h12, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 2};
        tbl[3]  = '{1'b1, 8'h13, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 3};
        tbl[4]  = '{1'b1, 8'h14, 1'b0, 1'b0, 1'b1, 8'h10, 1'b1, 4};
        tbl[5]  = '{1'b1, 8'h14, 1'b0, 1'b0, 1'b1, 8'h10, 1'b1, 4};
        tbl[6]  = '{1'b1, 8'h14, 1'b1, 1'b1, 1'b1, 8'h10, 1'b1, 4};
        tbl[7]  = '{1'b1, 8'h15, 1'b1, 1'b1, 1'b1, 8'h11, 1'b1, 4};
        tbl[8]  = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 8'h12, 1'b1, 4};
        tbl[9]  = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 8'h13, 1'b1, 3};
        tbl[10] = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 8'h14, 1'b1, 2};
        tbl[11] = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 8'h15, 1'b1, 1};
        tbl[12] = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 8'h00, 1'b0, 0};

        // Reset state and asynchronous reset assertion between edges.
        #3;
        chk_outs("reset", 1'b1, 1'b0, RV, 1'b1, 0);
        do_reset();
        drive(1'b1, 8'h5E, 1'b0);
        drive(1'b1, 8'h6F, 1'b0);
        #2;
        rst = 1'b1;
        #1;
        chk_outs("s1_async_rst", 1'b1, 1'b0, RV, 1'b1, 0);
        @(negedge clk);
        rst = 1'b0;

        // Table: stalled fill and drain.
        do_reset();
        for (int i = 0; i < 13; i++) begin
            drive(tbl[i].iv, tbl[i].din, tbl[i].ordy);
            chk_outs($sformatf("s3_row%0d", i), tbl[i].e_ir, tbl[i].e_ov,
                     tbl[i].e_od, tbl[i].chk_od, tbl[i].e_cnt);
        end

        // Streaming with no stall: latency DEPTH, one word per cycle.
        do_reset();
        for (int c = 0; c <= 12; c++) begin
            int ecnt;
            drive(c < 8, 8'(c + 1), 1'b1);
            ecnt = (c < 4) ? c : (c <= 8) ? 4 : 12 - c;
            if (c >= 4 && c < 12)
                chk_outs($sformatf("s2_c%0d", c), 1'b1, 1'b1, 8'(c - 3), 1'b1, ecnt);
            else
                chk_outs($sformatf("s2_c%0d", c), 1'b1, 1'b0, 8'h00, 1'b0, ecnt);
        end

        // Bubble collapse behind a stalled head word.
        do_reset();
        drive(1'b1, 8'h3C, 1'b0);
        drive(1'b0, 8'h00, 1'b0);
        drive(1'b0, 8'h00, 1'b0);
        drive(1'b0, 8'h00, 1'b0);
        drive(1'b1, 8'h5A, 1'b0);
        chk_outs("s4_head", 1'b1, 1'b1, 8'h3C, 1'b1, 1);
        drive(1'b0, 8'h00, 1'b0);
        drive(1'b0, 8'h00, 1'b0);
        drive(1'b0, 8'h00, 1'b0);
        chk_outs("s4_stall", 1'b1, 1'b1, 8'h3C, 1'b1, 2);
        drive(1'b0, 8'h00, 1'b1);
        chk_outs("s4_out0", 1'b1, 1'b1, 8'h3C, 1'b1, 2);
        drive(1'b0, 8'h00, 1'b1);
        chk_outs("s4_out1", 1'b1, 1'b1, 8'h5A, 1'b1, 1);
        drive(1'b0, 8'h00, 1'b1);
        chk_outs("s4_empty", 1'b1, 1'b0, 8'h00, 1'b0, 0);

        // Reset pulse with three words in flight, then a clean restart.
        do_reset();
        for (int i = 0; i < 3; i++) drive(1'b1, 8'(8'h20 + i), 1'b0);
        drive(1'b0, 8'h00, 1'b0);
        chk_outs("s5_pre", 1'b1, 1'b0, 8'h00, 1'b0, 3);
        #2;
        rst = 1'b1;
        #1;
        chk_outs("s5_rst", 1'b1, 1'b0, RV, 1'b1, 0);
        @(negedge clk);
        rst = 1'b0;
        for (int c = 0; c <= 5; c++) begin
            drive(c == 0, 8'h77, 1'b1);
            chk_outs($sformatf("s5_c%0d", c), 1'b1, c == 4, 8'h77, c == 4,
                     (c >= 1 && c <= 4) ? 1 : 0);
        end

`ifdef PIPE_SYNC_CLR_EN
        // Synchronous flush wins over an offered word.
        do_reset();
        for (int i = 0; i < 3; i++) drive(1'b1, 8'(8'h40 + i), 1'b0);
        @(negedge clk);
        clr      = 1'b1;
        in_valid = 1'b1;
        in_data  = 8'h99;
        #1;
        chk("s6_in_ready", 32'(in_ready), 32'd0);
        @(negedge clk);
        clr      = 1'b0;
        in_valid = 1'b0;
        #1;
        chk_outs("s6_after", 1'b1, 1'b0, 8'h00, 1'b0, 0);
        for (int c = 0; c < 5; c++) begin
            drive(1'b0, 8'h00, 1'b1);
            chk_outs($sformatf("s6_idle%0d", c), 1'b1, 1'b0, 8'h00, 1'b0, 0);
        end
`endif

        // Randomized traffic against the reference model.
        do_reset();
        m_clear();
        for (int c = 0; c < 3000; c++) begin
            logic       iv, ordy;
            logic [7:0] din;
            int         pct;
            int         mc;
            pct  = ((c / 300) % 2 == 0) ? 75 : 30;
            iv   = ($urandom_range(0, 99) < 60);
            ordy = ($urandom_range(0, 99) < pct);
            din  = 8'($urandom);
            drive(iv, din, ordy);
            mc = m_count();
            chk_outs("rand", (mc < D) || ordy, mv[D-1], md[D-1], mv[D-1], mc);
            m_step(iv, din, ordy);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
